// File: rtl/stroke_pkg.sv
// Shared types for the stroke rasteriser.
// State encoding, error-term width and an abs helper.
package stroke_pkg;

  localparam int COORD_W_DEF = 10;
  localparam int ERR_W       = COORD_W_DEF + 2;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STEP,
    BRUSH,
    DONE
  } state_t;

  function automatic logic signed [31:0] abs_s(
    input logic signed [31:0] v
  );
    return (v < 0) ? -v : v;
  endfunction

endpackage

// File: rtl/stroke_rasterizer_brush.sv
// Square brush offset scanner: walks (ox, oy) over the brush,
// forms the target pixel and flags off-canvas targets.
module brush_scan
  import stroke_pkg::*;
#(
  parameter int COORD_W = 10,
  parameter int MAX_X   = 639,
  parameter int MAX_Y   = 479,
  parameter int PEN_R   = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_en,
  input  logic               i_ack,
  input  logic [COORD_W-1:0] i_cx,
  input  logic [COORD_W-1:0] i_cy,
  output logic               o_hit,
  output logic [COORD_W-1:0] o_tx,
  output logic [COORD_W-1:0] o_ty,
  output logic               o_done
);

  localparam int EW = COORD_W + (ERR_W - COORD_W_DEF);
  localparam logic signed [3:0] R_LO = 4'(-PEN_R);
  localparam logic signed [3:0] R_HI = 4'(PEN_R);
  localparam logic signed [EW-1:0] LIM_X = EW'(MAX_X);
  localparam logic signed [EW-1:0] LIM_Y = EW'(MAX_Y);

  logic signed [3:0]    r_ox;
  logic signed [3:0]    r_oy;
  logic signed [EW-1:0] w_tx;
  logic signed [EW-1:0] w_ty;
  logic                 w_hit;
  logic                 w_last;
  logic                 w_adv;

  assign w_tx = $signed({2'b00, i_cx}) + EW'(r_ox);
  assign w_ty = $signed({2'b00, i_cy}) + EW'(r_oy);

  assign w_hit = !w_tx[EW-1] && (w_tx <= LIM_X)
              && !w_ty[EW-1] && (w_ty <= LIM_Y);

  assign w_last = (r_ox == R_HI) && (r_oy == R_HI);

  // Clipped targets advance unconditionally; real ones wait for the ack.
  assign w_adv = i_en && (!w_hit || i_ack);

  assign o_hit  = w_hit;
  assign o_tx   = w_tx[COORD_W-1:0];
  assign o_ty   = w_ty[COORD_W-1:0];
  assign o_done = w_adv && w_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ox <= R_LO;
      r_oy <= R_LO;
    end else if (w_adv) begin
      if (r_ox == R_HI) begin
        r_ox <= R_LO;
        r_oy <= w_last ? R_LO : r_oy + 4'sd1;
      end else begin
        r_ox <= r_ox + 4'sd1;
      end
    end
  end

endmodule

// File: rtl/stroke_rasterizer.sv
// Pointer-sample line drawer: Bresenham over pen-down segments,
// square brush stamp, backpressured pixel write port.
module stroke_rasterizer
  import stroke_pkg::*;
#(
  parameter int COORD_W = 10,
  parameter int MAX_X   = 639,
  parameter int MAX_Y   = 479,
  parameter int DATA_W  = 1,
  parameter int PEN_R   = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pt_valid,
  output logic               pt_ready,
  input  logic [COORD_W-1:0] pt_x,
  input  logic [COORD_W-1:0] pt_y,
  input  logic               pt_pen,
  input  logic [DATA_W-1:0]  pt_color,
  output logic               wr_valid,
  input  logic               wr_ready,
  output logic [COORD_W-1:0] wr_x,
  output logic [COORD_W-1:0] wr_y,
  output logic [DATA_W-1:0]  wr_data,
  output logic               busy,
  output logic               seg_done
);

  localparam int EW = COORD_W + (ERR_W - COORD_W_DEF);

  state_t               r_state;
  logic [COORD_W-1:0]   r_ax;
  logic [COORD_W-1:0]   r_ay;
  logic                 r_last_pen;
  logic [COORD_W-1:0]   r_x0;
  logic [COORD_W-1:0]   r_y0;
  logic [COORD_W-1:0]   r_x1;
  logic [COORD_W-1:0]   r_y1;
  logic [DATA_W-1:0]    r_col;
  logic [COORD_W-1:0]   r_cx;
  logic [COORD_W-1:0]   r_cy;
  logic signed [EW-1:0] r_dx;
  logic signed [EW-1:0] r_dy;
  logic signed [EW-1:0] r_err;
  logic                 r_sx_neg;
  logic                 r_sy_neg;

  logic signed [EW-1:0] w_ddx;
  logic signed [EW-1:0] w_ddy;
  logic signed [EW-1:0] w_adx;
  logic signed [EW-1:0] w_ady;
  logic signed [EW-1:0] w_e2;
  logic                 w_xstep;
  logic                 w_ystep;
  logic signed [EW-1:0] w_err_n;
  logic [COORD_W-1:0]   w_cx_n;
  logic [COORD_W-1:0]   w_cy_n;
  logic                 w_at_end;
  logic                 w_hit;
  logic [COORD_W-1:0]   w_tx;
  logic [COORD_W-1:0]   w_ty;
  logic                 w_bdone;
  logic                 w_same;

  assign w_ddx = $signed({2'b00, r_x1}) - $signed({2'b00, r_x0});
  assign w_ddy = $signed({2'b00, r_y1}) - $signed({2'b00, r_y0});
  assign w_adx = EW'(abs_s(32'(w_ddx)));
  assign w_ady = EW'(abs_s(32'(w_ddy)));

  // Both axis decisions look at the error term from before this step.
  assign w_e2    = r_err <<< 1;
  assign w_xstep = (w_e2 >= r_dy);
  assign w_ystep = (w_e2 <= r_dx);
  assign w_err_n = r_err + (w_xstep ? r_dy : '0)
                         + (w_ystep ? r_dx : '0);

  assign w_cx_n = !w_xstep ? r_cx
                : r_sx_neg ? r_cx - COORD_W'(1)
                :            r_cx + COORD_W'(1);
  assign w_cy_n = !w_ystep ? r_cy
                : r_sy_neg ? r_cy - COORD_W'(1)
                :            r_cy + COORD_W'(1);

  assign w_at_end = (r_cx == r_x1) && (r_cy == r_y1);
  assign w_same   = (pt_x == r_ax) && (pt_y == r_ay);

  brush_scan #(
    .COORD_W (COORD_W),
    .MAX_X   (MAX_X),
    .MAX_Y   (MAX_Y),
    .PEN_R   (PEN_R)
  ) u_brush (
    .clk    (clk),
    .rst    (rst),
    .i_en   (r_state == BRUSH),
    .i_ack  (wr_ready),
    .i_cx   (r_cx),
    .i_cy   (r_cy),
    .o_hit  (w_hit),
    .o_tx   (w_tx),
    .o_ty   (w_ty),
    .o_done (w_bdone)
  );

  assign pt_ready = (r_state == IDLE);
  assign busy     = (r_state != IDLE);
  assign seg_done = (r_state == DONE);
  assign wr_valid = (r_state == BRUSH) && w_hit;
  assign wr_x     = wr_valid ? w_tx  : '0;
  assign wr_y     = wr_valid ? w_ty  : '0;
  assign wr_data  = wr_valid ? r_col : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ax       <= '0;
      r_ay       <= '0;
      r_last_pen <= 1'b0;
      r_x0       <= '0;
      r_y0       <= '0;
      r_x1       <= '0;
      r_y1       <= '0;
      r_col      <= '0;
      r_cx       <= '0;
      r_cy       <= '0;
      r_dx       <= '0;
      r_dy       <= '0;
      r_err      <= '0;
      r_sx_neg   <= 1'b0;
      r_sy_neg   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (pt_valid) begin
            r_x1  <= pt_x;
            r_y1  <= pt_y;
            r_col <= pt_color;
            if (!pt_pen) begin
              r_ax       <= pt_x;
              r_ay       <= pt_y;
              r_last_pen <= 1'b0;
            end else if (!r_last_pen) begin
              r_x0    <= pt_x;
              r_y0    <= pt_y;
              r_state <= SETUP;
            end else if (!w_same) begin
              r_x0    <= r_ax;
              r_y0    <= r_ay;
              r_state <= SETUP;
            end
          end
        end
        SETUP: begin
          r_dx     <= w_adx;
          r_dy     <= -w_ady;
          r_err    <= w_adx - w_ady;
          r_sx_neg <= (r_x1 < r_x0);
          r_sy_neg <= (r_y1 < r_y0);
          r_cx     <= r_x0;
          r_cy     <= r_y0;
          r_state  <= BRUSH;
        end
        BRUSH: begin
          if (w_bdone) begin
            r_state <= w_at_end ? DONE : STEP;
          end
        end
        STEP: begin
          r_err   <= w_err_n;
          r_cx    <= w_cx_n;
          r_cy    <= w_cy_n;
          r_state <= BRUSH;
        end
        DONE: begin
          r_ax       <= r_x1;
          r_ay       <= r_y1;
          r_last_pen <= 1'b1;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/stroke_rasterizer.md
Name: stroke_rasterizer

Overview:
- Parametrised successor of the mouse-to-canvas line drawer.
- Accepts a stream of pointer samples over a valid/ready handshake and rasterises pen-down segments with the general-octant Bresenham algorithm.
- Stamps a square brush at every line point and emits pixel writes over a backpressured valid/ready port toward the canvas RAM arbiter.
- Sits between the mouse event decoder and the canvas write arbiter.

Parameters:
- COORD_W, 10, width of the x/y coordinate in pixels.
- MAX_X, 639, largest legal x; brush pixels beyond it are clipped.
- MAX_Y, 479, largest legal y; brush pixels beyond it are clipped.
- DATA_W, 1, pixel colour width.
- PEN_R, 0, brush radius; the brush is a square of side 2*PEN_R+1, range 0..3.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- pt_valid  in  1  a sample is offered.
- pt_ready  out  1  block accepts the sample this cycle.
- pt_x  in  COORD_W  sample x.
- pt_y  in  COORD_W  sample y.
- pt_pen  in  1  1 = pen down (draw), 0 = move only.
- pt_color  in  DATA_W  colour for the segment ending at this sample.
- wr_valid  out  1  pixel write offered.
- wr_ready  in  1  the consumer takes the write.
- wr_x  out  COORD_W  pixel x.
- wr_y  out  COORD_W  pixel y.
- wr_data  out  DATA_W  pixel colour.
- busy  out  1  block is not in IDLE.
- seg_done  out  1  one-cycle pulse when a segment's last write completes.

Behaviour:
- Reset values:
  - All outputs are 0 except pt_ready = 1.
  - Anchor (ax, ay) = (0, 0); last_pen = 0; state = IDLE.
- States: IDLE, SETUP, STEP, BRUSH, DONE.
- IDLE:
  - pt_ready = 1.
  - On pt_valid, latch pt_x, pt_y, pt_pen and pt_color.
  - Pen up: anchor <= pt; last_pen <= 0; remain in IDLE. Accepting the sample takes one cycle and produces no writes.
  - Pen down with last_pen = 0: the segment is the single point pt to pt; go to SETUP.
  - Pen down with last_pen = 1 and pt equal to the anchor: no writes; remain in IDLE.
  - Pen down otherwise: the segment runs from the anchor to pt; go to SETUP.
- SETUP (1 cycle):
  - dx = |x1-x0|; dy = -|y1-y0|.
  - sx and sy = +/-1; err = dx + dy.
  - Signed width is COORD_W+2 for dx, dy, err and e2.
  - Current point (cx, cy) = (x0, y0); go to BRUSH.
- BRUSH:
  - Scans brush offsets (ox, oy) over -PEN_R..PEN_R, oy outer and ox inner, one offset per cycle.
  - The target is (cx+ox, cy+oy).
  - Clipping: a target with a coordinate < 0, > MAX_X or > MAX_Y is skipped. A skipped target consumes one cycle with wr_valid = 0.
  - For an in-range target, wr_valid = 1 and wr_x, wr_y, wr_data are held stable until wr_ready. The scan advances only on a wr_valid && wr_ready handshake.
  - After the last offset: if (cx, cy) equals the endpoint, go to DONE; otherwise go to STEP.
- STEP (1 cycle):
  - e2 = 2*err.
  - If e2 >= dy: err += dy and cx += sx.
  - If e2 <= dx: err += dx and cy += sy.
  - Both updates use the pre-step err; go to BRUSH.
- DONE (1 cycle):
  - seg_done = 1; anchor <= endpoint; last_pen <= 1; go to IDLE.
- Endpoints are inclusive. Interior points are shared across consecutive segments; the shared joint is drawn twice, which is accepted.
- Latency: the accept cycle is followed by SETUP, so the first wr_valid is asserted 2 cycles after the accept when there is no clip.
- busy = (state != IDLE).
- pt_ready = 0 outside IDLE; samples are held off by the producer, never dropped.
- rst asserted mid-segment:
  - The next cycle is IDLE with wr_valid = 0 and the anchor at (0, 0).
  - No seg_done pulse is produced.
  - A pending write is abandoned.
- wr_ready high without wr_valid is ignored.

Decomposition:
- Package stroke_pkg holds:
  - the state enum (IDLE/SETUP/STEP/BRUSH/DONE);
  - the signed width constant ERR_W = COORD_W+2;
  - an abs function.
- Sub-module brush_scan holds the offset counters, target adder, clip compare and last-offset flag, with a step/done interface to the parent FSM.

Test Plan:
- PEN_R=0. Samples (0,0,pen up) then (5,0,pen down) -> writes (0,0),(1,0),(2,0),(3,0),(4,0),(5,0), then one seg_done; the anchor becomes (5,0).
- PEN_R=0. Samples (0,0,up) then (2,5,down) -> writes exactly (0,0),(0,1),(1,2),(1,3),(2,4),(2,5) in that order.
- Segment of the first scenario with wr_ready low for 3 cycles on every second write -> the write sequence is unchanged, with wr_x/wr_y stable while stalled, and pt_ready = 0 throughout.
- PEN_R=1. Samples (0,0,up) then (0,0,down) -> only (0,0),(1,0),(0,1),(1,1) are written; the 5 clipped offsets are skipped; seg_done pulses once.
- Samples (3,3,down) then (3,3,down) -> the first produces 1 write; the second is accepted in 1 cycle with 0 writes and no seg_done.
- rst asserted during the 3rd write of the (0,0)->(5,0) segment -> next cycle wr_valid = 0, busy = 0, pt_ready = 1; sample (2,0,down) then draws only (2,0).
